// File: rtl/encoder_axil_pkg.sv
// rtl/encoder_axil_pkg.sv - register map, CTRL bit positions, response codes and decoder step type
package encoder_axil_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_POSITION = 2'd1;
  localparam logic [1:0] REG_VELOCITY = 2'd2;
  localparam logic [1:0] REG_WINDOW   = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;
  localparam int CTRL_CLR = 2;
  localparam int CTRL_ZEN = 3;
  localparam int CTRL_ERR = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR} step_t;

  // Maps the Gray phase 00,01,11,10 onto 0..3 so a step is a modulo-4 difference.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - synchronises A/B (and Z under ENC_INDEX_EN), emits a registered step/error
module quad_decoder
  import encoder_axil_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_a,
  input  logic  i_b,
  output step_t o_step
`ifdef ENC_INDEX_EN
  ,
  input  logic  i_z,
  output logic  o_z_rise
`endif
);

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [1:0]             r_prev;
  logic [1:0]             w_cur;
  logic [1:0]             w_diff;
  step_t                  w_step;
  step_t                  r_step;

  assign w_cur  = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
  assign w_diff = gray2bin(w_cur) - gray2bin(r_prev);
  assign o_step = r_step;

  always_comb begin
    w_step = STEP_NONE;
    case (w_diff)
      2'd0:    w_step = STEP_NONE;
      2'd1:    w_step = STEP_INC;
      2'd3:    w_step = STEP_DEC;
      default: w_step = STEP_ERR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_prev   <= 2'b00;
      r_step   <= STEP_NONE;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], i_a};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], i_b};
      r_prev   <= w_cur;
      r_step   <= w_step;
    end
  end

`ifdef ENC_INDEX_EN
  logic [SYNC_STAGES-1:0] r_sync_z;
  logic                   r_prev_z;
  logic                   r_z_rise;

  assign o_z_rise = r_z_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_z <= '0;
      r_prev_z <= 1'b0;
      r_z_rise <= 1'b0;
    end else begin
      r_sync_z <= {r_sync_z[SYNC_STAGES-2:0], i_z};
      r_prev_z <= r_sync_z[SYNC_STAGES-1];
      r_z_rise <= r_sync_z[SYNC_STAGES-1] & ~r_prev_z;
    end
  end
`endif

endmodule

// File: rtl/encoder_axil_slave.sv
// rtl/encoder_axil_slave.sv - AXI4-Lite quadrature encoder peripheral: position, velocity, window
// ENC_INDEX_EN adds the enc_z index input and CTRL.ZEN.
module encoder_axil_slave
  import encoder_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int WINDOW_RESET       = 100000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            enc_a,
  input  logic                            enc_b,
`ifdef ENC_INDEX_EN
  input  logic                            enc_z,
`endif
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  logic        r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]  r_bresp;
  logic [31:0] r_rdata;
  logic        r_en, r_inv, r_err, r_zen;
  logic [31:0] r_position, r_velocity, r_window, r_win_cnt, r_snapshot;

  step_t       w_step;
  logic        w_wr_fire, w_rd_fire, w_wr_ctrl, w_wr_pos, w_wr_win;
  logic        w_zero, w_err_w1c, w_count, w_fwd, w_z_event;
  logic [31:0] w_wmask, w_pos_wdata, w_win_wdata, w_delta, w_rd_mux;
  logic        w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifdef ENC_INDEX_EN
  logic w_z_rise;
  quad_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
    .i_clk(ACLK), .i_rst_n(ARESETN), .i_a(enc_a), .i_b(enc_b), .o_step(w_step),
    .i_z(enc_z), .o_z_rise(w_z_rise)
  );
  assign w_z_event = w_z_rise & r_zen & r_en;
`else
  quad_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_dec (
    .i_clk(ACLK), .i_rst_n(ARESETN), .i_a(enc_a), .i_b(enc_b), .o_step(w_step)
  );
  assign w_z_event = 1'b0;
`endif

  assign w_wr_fire   = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_fire   = r_arready & S_AXI_ARVALID;
  assign w_wr_ctrl   = w_wr_fire && (S_AXI_AWADDR[3:2] == REG_CTRL);
  assign w_wr_pos    = w_wr_fire && (S_AXI_AWADDR[3:2] == REG_POSITION);
  assign w_wr_win    = w_wr_fire && (S_AXI_AWADDR[3:2] == REG_WINDOW);
  assign w_wmask     = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                        {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
  assign w_pos_wdata = (r_position & ~w_wmask) | (S_AXI_WDATA & w_wmask);
  assign w_win_wdata = (r_window & ~w_wmask) | (S_AXI_WDATA & w_wmask);
  assign w_err_w1c   = w_wr_ctrl & S_AXI_WSTRB[1] & S_AXI_WDATA[CTRL_ERR];
  assign w_zero      = (w_wr_ctrl & S_AXI_WSTRB[0] & S_AXI_WDATA[CTRL_CLR]) | w_z_event;
  assign w_count     = r_en & ((w_step == STEP_INC) | (w_step == STEP_DEC));
  assign w_fwd       = (w_step == STEP_INC) ^ r_inv;
  assign w_delta     = w_fwd ? 32'd1 : 32'hFFFF_FFFF;

  always_comb begin
    w_rd_mux = 32'd0;
    case (S_AXI_ARADDR[3:2])
      REG_CTRL:     w_rd_mux = {23'd0, r_err, 4'd0, r_zen, 1'b0, r_inv, r_en};
      REG_POSITION: w_rd_mux = r_position;
      REG_VELOCITY: w_rd_mux = r_velocity;
      default:      w_rd_mux = r_window;
    endcase
  end

  // Ready is registered: it rises one cycle after both valids appear and the
  // handshake completes in the cycle it is high.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_awready <= ~r_awready & S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (S_AXI_AWADDR[3:2] == REG_VELOCITY) ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= ~r_arready & S_AXI_ARVALID & ~r_rvalid;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_en       <= 1'b0;
      r_inv      <= 1'b0;
      r_zen      <= 1'b0;
      r_err      <= 1'b0;
      r_position <= 32'd0;
      r_velocity <= 32'd0;
      r_snapshot <= 32'd0;
      r_window   <= 32'(WINDOW_RESET);
      r_win_cnt  <= 32'(WINDOW_RESET);
    end else begin
      if (w_wr_ctrl && S_AXI_WSTRB[0]) begin
        r_en  <= S_AXI_WDATA[CTRL_EN];
        r_inv <= S_AXI_WDATA[CTRL_INV];
`ifdef ENC_INDEX_EN
        r_zen <= S_AXI_WDATA[CTRL_ZEN];
`endif
      end
      r_err <= (r_err & ~w_err_w1c) | (w_step == STEP_ERR);

      // Clear/index beats a bus write, which beats a decoder step.
      if (w_zero)        r_position <= 32'd0;
      else if (w_wr_pos) r_position <= w_pos_wdata;
      else if (w_count)  r_position <= r_position + w_delta;

      if (w_wr_win) begin
        r_window  <= w_win_wdata;
        r_win_cnt <= w_win_wdata;
      end else if (r_en && (r_window != 32'd0)) begin
        if (r_win_cnt <= 32'd1) begin
          r_velocity <= r_position - r_snapshot;
          r_snapshot <= r_position;
          r_win_cnt  <= r_window;
        end else begin
          r_win_cnt <= r_win_cnt - 32'd1;
        end
      end
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_encoder_axil_slave.sv
// tb/tb_encoder_axil_slave.sv - scoreboard bench for encoder_axil_slave
module tb_encoder_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        enc_a, enc_b, enc_z;
  logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [31:0] S_AXI_RDATA;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [1:0]  gray_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int          g = 0;
  logic [31:0] pos_m = 32'd0;
  logic        en_m = 1'b0;
  logic        inv_m = 1'b0;

  always #5 ACLK = ~ACLK;

  encoder_axil_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enc_a(enc_a), .enc_b(enc_b),
`ifdef ENC_INDEX_EN
    .enc_z(enc_z),
`endif
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input string tag, input int hold);
    int n;
    int stable;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 50);
    check({tag, "_awready"}, 32'(S_AXI_AWREADY & S_AXI_WREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge ACLK); n++; end
    check({tag, "_bvalid"}, 32'(S_AXI_BVALID), 32'd1);
    stable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID && S_AXI_BRESP == exp_resp) stable++;
    end
    if (hold > 0) check({tag, "_bhold"}, 32'(stable), 32'(hold));
    check({tag, "_bresp"}, 32'(S_AXI_BRESP), 32'(exp_resp));
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag,
                          input int hold);
    int n;
    int stable;
    logic [31:0] first;
    logic [31:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 50);
    check({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
    check({tag, "_rvalid"}, 32'(S_AXI_RVALID), 32'd1);
    first = S_AXI_RDATA;
    stable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID && S_AXI_RDATA == first) stable++;
    end
    if (hold > 0) check({tag, "_rhold"}, 32'(stable), 32'(hold));
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, first, e);
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  // dir +1/-1 is a legal Gray step, 2 flips both channels at once.
  task automatic enc_step(input int dir);
    g = (g + dir) & 3;
    {enc_a, enc_b} = gray_tbl[g];
    if ((dir == 1 || dir == -1) && en_m) pos_m = pos_m + 32'(inv_m ? -dir : dir);
    repeat (4) @(posedge ACLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic aw_seen, ar_seen;
    ARESETN = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (4) @(posedge ACLK);
    #1;
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    axi_read(4'h0, 32'd0, "rst_ctrl", 0);
    axi_read(4'h4, 32'd0, "rst_pos", 0);
    axi_read(4'h8, 32'd0, "rst_vel", 0);
    axi_read(4'hC, 32'd100000, "rst_win", 0);

    // Basic register map, SLVERR on VELOCITY
    axi_write(4'h0, 32'h1, 4'hF, 2'b00, "w_ctrl", 0); en_m = 1'b1;
    axi_write(4'h4, 32'h10, 4'hF, 2'b00, "w_pos", 0); pos_m = 32'h10;
    axi_write(4'h8, 32'h55, 4'hF, 2'b10, "w_vel", 0);
    axi_write(4'hC, 32'h20, 4'hF, 2'b00, "w_win", 0);
    axi_read(4'h0, 32'h1, "map_ctrl", 0);
    axi_read(4'h4, 32'h10, "map_pos", 0);
    axi_read(4'h8, 32'h0, "map_vel", 0);
    axi_read(4'hC, 32'h20, "map_win", 0);
    axi_write(4'hC, 32'h0, 4'hF, 2'b00, "w_win0", 0);
    axi_write(4'h4, 32'hAABBCCDD, 4'h3, 2'b00, "w_strb", 0);
    axi_read(4'h4, 32'h0000CCDD, "strb_pos", 0);
    axi_write(4'h0, 32'h5, 4'hF, 2'b00, "w_clr", 0); pos_m = 32'd0;
    axi_read(4'h4, 32'h0, "clr_pos", 0);
    axi_read(4'h0, 32'h1, "clr_ctrl", 0);

    // Counting forward, then inverted
    for (int i = 0; i < 8; i++) enc_step(1);
    repeat (2) @(posedge ACLK);
    axi_read(4'h4, pos_m, "fwd8", 0);
    axi_write(4'h0, 32'h3, 4'hF, 2'b00, "w_inv", 0); inv_m = 1'b1;
    for (int i = 0; i < 8; i++) enc_step(1);
    repeat (2) @(posedge ACLK);
    axi_read(4'h4, pos_m, "inv8", 0);
    axi_write(4'h0, 32'h1, 4'hF, 2'b00, "w_noinv", 0); inv_m = 1'b0;
    enc_step(-1);
    repeat (2) @(posedge ACLK);
    axi_read(4'h4, pos_m, "rev1", 0);

    // Signed wrap
    axi_write(4'h4, 32'h7FFFFFFF, 4'hF, 2'b00, "w_max", 0); pos_m = 32'h7FFFFFFF;
    enc_step(1);
    repeat (2) @(posedge ACLK);
    axi_read(4'h4, 32'h80000000, "wrap", 0);

    // Illegal transition
    enc_step(2);
    repeat (2) @(posedge ACLK);
    axi_read(4'h4, pos_m, "ill_pos", 0);
    axi_read(4'h0, 32'h101, "ill_err", 0);
    axi_write(4'h0, 32'h101, 4'hF, 2'b00, "w_w1c", 0);
    axi_read(4'h0, 32'h1, "w1c_ctrl", 0);

    // Velocity over a 100-cycle window, then frozen with WINDOW=0
    axi_write(4'hC, 32'd100, 4'hF, 2'b00, "w_win100", 0);
    repeat (150) @(posedge ACLK);
    #1;
    axi_write(4'hC, 32'd100, 4'hF, 2'b00, "w_win100b", 0);
    for (int i = 0; i < 5; i++) enc_step(1);
    repeat (100) @(posedge ACLK);
    #1;
    axi_read(4'h8, 32'd5, "vel5", 0);
    axi_write(4'hC, 32'd0, 4'hF, 2'b00, "w_winfrz", 0);
    for (int i = 0; i < 3; i++) enc_step(1);
    repeat (250) @(posedge ACLK);
    #1;
    axi_read(4'h8, 32'd5, "vel_frozen", 0);

    // Back-pressure on both response channels
    axi_write(4'h4, 32'h1234, 4'hF, 2'b00, "bp_w", 10); pos_m = 32'h1234;
    axi_read(4'h4, 32'h1234, "bp_r", 10);

    // Simultaneous write/read of POSITION, then reset with both responses pending
    enc_a = 1'b0; enc_b = 1'b0; g = 0;
    repeat (6) @(posedge ACLK);
    #1;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'hDEAD0000; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!(S_AXI_BVALID && S_AXI_RVALID) && n < 20) begin
      @(negedge ACLK);
      aw_seen = S_AXI_AWREADY;
      ar_seen = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (aw_seen) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
      if (ar_seen) S_AXI_ARVALID = 1'b0;
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("both_bvalid", 32'(S_AXI_BVALID), 32'd1);
    check("both_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("same_cycle_old", S_AXI_RDATA, pos_m);
    #2;
    ARESETN = 1'b0;
    #1;
    check("arst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("arst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("arst_rdata", S_AXI_RDATA, 32'd0);
    check("arst_ready", 32'({S_AXI_AWREADY, S_AXI_ARREADY}), 32'd0);
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    en_m = 1'b0; pos_m = 32'd0;
    @(posedge ACLK); #1;
    axi_read(4'h0, 32'd0, "post_ctrl", 0);
    axi_read(4'h4, 32'd0, "post_pos", 0);
    axi_read(4'h8, 32'd0, "post_vel", 0);
    axi_read(4'hC, 32'd100000, "post_win", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_axil_slave.md
Name: encoder_axil_slave

Overview:
AXI4-Lite slave peripheral for the kart's motor-shaft quadrature encoder. It is the responder end of the AXI4-Lite master bus that the processor and the verification master drive.
- Decodes synchronised A/B channels into a signed 32-bit position.
- Computes velocity over a programmable window.
- Exposes control, position, velocity and window through four word registers.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register
SYNC_STAGES, 2, flip-flop stages on each encoder input (minimum 2)
WINDOW_RESET, 100000, reset value of the WINDOW register, in ACLK cycles

Ports:
ACLK  in  1  sole clock
ARESETN  in  1  asynchronous active-low reset
enc_a  in  1  encoder channel A, asynchronous to ACLK
enc_b  in  1  encoder channel B, asynchronous to ACLK
S_AXI_AWADDR/AWPROT/AWVALID  in  4/3/1  write address channel; AWPROT ignored
S_AXI_AWREADY  out  1  write address accept
S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel
S_AXI_WREADY  out  1  write data accept
S_AXI_BRESP/BVALID  out  2/1  write response
S_AXI_BREADY  in  1  write response accept
S_AXI_ARADDR/ARPROT/ARVALID  in  4/3/1  read address channel; ARPROT ignored
S_AXI_ARREADY  out  1  read address accept
S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data channel
S_AXI_RREADY  in  1  read data accept

Behaviour:
- Clocking and reset: one clock, ACLK. Reset is asynchronous and active-low on ARESETN.
- Reset values:
  - All READY and VALID outputs 0; RDATA 0; BRESP and RRESP 00.
  - CTRL 0; POSITION 0; VELOCITY 0; WINDOW = WINDOW_RESET.
  - Synchroniser flops 0; window counter = WINDOW_RESET.
- Register map (byte address; bits [1:0] ignored):
  - 0x0 CTRL. bit0 EN; bit1 INV (negates step direction); bit2 CLR, writes 1 to zero POSITION, self-clearing, reads 0; bit8 ERR, sticky illegal-transition flag, write-1-to-clear; other bits read 0.
  - 0x4 POSITION, RW, signed.
  - 0x8 VELOCITY, RO, signed.
  - 0xC WINDOW, RW, unsigned.
- Write channel:
  - AWREADY and WREADY pulse high together for exactly one cycle when AWVALID && WVALID && !BVALID.
  - The register update happens in that same cycle, honouring WSTRB per byte lane.
  - BVALID rises the next cycle and holds until BREADY; BVALID clears on BVALID && BREADY.
  - AW-only or W-only is never accepted alone; the block waits for both.
  - A write to 0x8 returns BRESP=10 (SLVERR) with no effect. All other writes return 00.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID && !RVALID.
  - RDATA is registered; RVALID rises the next cycle and holds, with RDATA stable, until RREADY.
  - RRESP is always 00.
- Independence: reads and writes may be accepted in the same cycle. A read of a register written in that cycle returns the old value.
- Decoder pipeline:
  - SYNC_STAGES flops on each input, then one previous-state register.
  - Gray sequence 00->01->11->10->00 is +1; the reverse is -1. INV negates the step.
  - Both bits changing is illegal: no count, ERR set.
  - Counting happens only when EN=1. ERR is set regardless of EN.
  - An input edge appears in POSITION SYNC_STAGES+2 cycles later.
- Arithmetic: POSITION is 32-bit two's complement and wraps (0x7FFFFFFF + 1 -> 0x80000000).
- Position priority, same cycle: CLR beats a bus write to POSITION, which beats a decoder step. A step colliding with a write or clear is dropped.
- ERR priority: a set in the same cycle as a W1C leaves ERR at 1.
- Velocity:
  - The window counter decrements each cycle while EN=1 and WINDOW != 0.
  - When the counter is 1: VELOCITY <= POSITION - snapshot, snapshot <= POSITION, counter reloads from WINDOW.
  - WINDOW=0 freezes the counter and VELOCITY.
  - A write to WINDOW reloads the counter immediately.
  - Clearing EN holds the counter without reloading.

Optional Feature:
ENC_INDEX_EN
- Defined:
  - Adds port enc_z (in, 1), synchronised the same way as A/B.
  - Adds CTRL bit3 ZEN.
  - When ZEN=1 and EN=1, a rising edge of synchronised Z zeroes POSITION, with the same priority as CLR.
- Undefined: no enc_z port; CTRL bit3 reads 0 and ignores writes.

Decomposition:
- Package encoder_axil_pkg holds:
  - register offset constants;
  - CTRL bit index constants;
  - the RESP_OKAY/RESP_SLVERR constants;
  - typedef enum for decoder step {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR}.
- Sub-module quad_decoder contains the synchronisers, previous-state register and step/error output. The AXI register file stays in the top.

Test Plan:
- Write 0x1,0x4(0x10),0x0(no),0xC(0x20) to regs 0x0-0xC, then read all four -> reads 0x00000001, 0x00000010, 0x00000000, 0x00000020; write to 0x8 gives BRESP=10.
- EN=1, drive 8 forward Gray steps (A/B held 4 cycles each) -> POSITION=8; set INV, 8 more forward steps -> POSITION=0.
- Write POSITION=0x7FFFFFFF, one forward step -> POSITION reads 0x80000000.
- Toggle A and B together -> POSITION unchanged, CTRL bit8=1; write 0x100 to CTRL -> bit8 reads 0.
- WINDOW=100, 5 forward steps within one window -> VELOCITY=5 after the window boundary; WINDOW=0 -> VELOCITY frozen.
- Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID and RDATA stable; assert ARESETN low mid-transaction -> all VALIDs 0 asynchronously and registers back to reset values.
